// File: rtl/spi_slave.sv
// SPI mode-0 peripheral: MSB-first receive/transmit shift registers behind pin synchronisers.
// Completed frames raise rx_valid; frames of the wrong length raise frame_err.
module spi_slave #(
   parameter int WIDTH       = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sclk,
   input  logic             mosi,
   input  logic             cs,
   output logic             miso,
   input  logic [WIDTH-1:0] tx_data,
   output logic [WIDTH-1:0] rx_data,
   output logic             rx_valid,
   output logic             frame_err,
   output logic             busy
);

   localparam int CNT_W = $clog2(WIDTH + 2);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);
   localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(WIDTH + 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [0:0] {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

   logic [SYNC_STAGES-1:0] sclk_sync_r, cs_sync_r, mosi_sync_r;
   logic                   sclk_dly_r, cs_dly_r;
   logic                   sclk_rise_s, sclk_fall_s, cs_rise_s, cs_fall_s, mosi_bit_s;

   state_t                 state_r, state_nx;
   logic [CNT_W-1:0]       bit_cnt_r, bit_cnt_nx;
   logic [WIDTH-1:0]       rx_shift_r, rx_shift_nx;
   logic [WIDTH-1:0]       tx_shift_r, tx_shift_nx;
   logic [WIDTH-1:0]       rx_data_r, rx_data_nx;
   logic                   miso_r, miso_nx;
   logic                   rx_valid_r, rx_valid_nx;
   logic                   frame_err_r, frame_err_nx;
   logic                   busy_r;

   // Pin synchronisers plus one-cycle delayed copies for edge detection
   always_ff @(posedge clk) begin
      if (rst) begin
         sclk_sync_r <= {SYNC_STAGES{1'b0}};
         cs_sync_r   <= {SYNC_STAGES{1'b0}};
         mosi_sync_r <= {SYNC_STAGES{1'b0}};
         sclk_dly_r  <= 1'b0;
         cs_dly_r    <= 1'b0;
      end else begin
         sclk_sync_r <= {sclk_sync_r[SYNC_STAGES-2:0], sclk};
         cs_sync_r   <= {cs_sync_r[SYNC_STAGES-2:0], cs};
         mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], mosi};
         sclk_dly_r  <= sclk_sync_r[SYNC_STAGES-1];
         cs_dly_r    <= cs_sync_r[SYNC_STAGES-1];
      end
   end

   assign sclk_rise_s = sclk_sync_r[SYNC_STAGES-1] & ~sclk_dly_r;
   assign sclk_fall_s = ~sclk_sync_r[SYNC_STAGES-1] & sclk_dly_r;
   assign cs_rise_s   = cs_sync_r[SYNC_STAGES-1] & ~cs_dly_r;
   assign cs_fall_s   = ~cs_sync_r[SYNC_STAGES-1] & cs_dly_r;
   assign mosi_bit_s  = mosi_sync_r[SYNC_STAGES-1];

   // Next-state and datapath logic; a cs rising edge takes priority over any sclk edge
   always_comb begin
      state_nx     = state_r;
      bit_cnt_nx   = bit_cnt_r;
      rx_shift_nx  = rx_shift_r;
      tx_shift_nx  = tx_shift_r;
      rx_data_nx   = rx_data_r;
      miso_nx      = miso_r;
      rx_valid_nx  = 1'b0;
      frame_err_nx = 1'b0;
      case (state_r)
         IDLE: begin
            if (cs_fall_s) begin
               state_nx    = ACTIVE;
               tx_shift_nx = tx_data;
               miso_nx     = tx_data[WIDTH-1];
               bit_cnt_nx  = {CNT_W{1'b0}};
            end else begin
               miso_nx = 1'b0;
            end
         end
         ACTIVE: begin
            if (cs_rise_s) begin
               state_nx = IDLE;
               miso_nx  = 1'b0;
               if (bit_cnt_r == CNT_FULL) begin
                  rx_data_nx  = rx_shift_r;
                  rx_valid_nx = 1'b1;
               end else begin
                  frame_err_nx = 1'b1;
               end
            end else if (sclk_rise_s) begin
               rx_shift_nx = {rx_shift_r[WIDTH-2:0], mosi_bit_s};
               if (bit_cnt_r != CNT_SAT) begin
                  bit_cnt_nx = bit_cnt_r + CNT_ONE;
               end else begin
                  bit_cnt_nx = bit_cnt_r;
               end
            end else if (sclk_fall_s) begin
               tx_shift_nx = {tx_shift_r[WIDTH-2:0], 1'b0};
               miso_nx     = tx_shift_r[WIDTH-2];
            end else begin
               tx_shift_nx = tx_shift_r;
            end
         end
         default: begin
            state_nx = IDLE;
            miso_nx  = 1'b0;
         end
      endcase
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= IDLE;
         bit_cnt_r   <= {CNT_W{1'b0}};
         rx_shift_r  <= {WIDTH{1'b0}};
         tx_shift_r  <= {WIDTH{1'b0}};
         rx_data_r   <= {WIDTH{1'b0}};
         miso_r      <= 1'b0;
         rx_valid_r  <= 1'b0;
         frame_err_r <= 1'b0;
         busy_r      <= 1'b0;
      end else begin
         state_r     <= state_nx;
         bit_cnt_r   <= bit_cnt_nx;
         rx_shift_r  <= rx_shift_nx;
         tx_shift_r  <= tx_shift_nx;
         rx_data_r   <= rx_data_nx;
         miso_r      <= miso_nx;
         rx_valid_r  <= rx_valid_nx;
         frame_err_r <= frame_err_nx;
         busy_r      <= (state_nx == ACTIVE);
      end
   end

   assign miso      = miso_r;
   assign rx_data   = rx_data_r;
   assign rx_valid  = rx_valid_r;
   assign frame_err = frame_err_r;
   assign busy      = busy_r;

endmodule

// File: tb/tb_spi_slave.sv
// Scoreboard bench for spi_slave: a bit-banged mode-0 master feeds a queue of expected
// frame outcomes that a separate monitor checks against rx_valid/frame_err pulses.
module tb_spi_slave;

   localparam int W    = 16;
   localparam int SYNC = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          sclk = 1'b0;
   logic          mosi = 1'b0;
   logic          cs = 1'b1;
   logic          miso;
   logic [W-1:0]  tx_data = 16'h0000;
   logic [W-1:0]  rx_data;
   logic          rx_valid, frame_err, busy;

   typedef struct {
      bit          is_err;
      logic [W-1:0] data;
      int          due;
   } exp_t;

   exp_t         exp_q[$];
   int           errors = 0;
   int           checks = 0;
   int           cyc = 0;
   logic [W-1:0] last_good = 16'h0000;

   spi_slave #(.WIDTH(W), .SYNC_STAGES(SYNC)) dut (
      .clk(clk), .rst(rst), .sclk(sclk), .mosi(mosi), .cs(cs), .miso(miso),
      .tx_data(tx_data), .rx_data(rx_data), .rx_valid(rx_valid),
      .frame_err(frame_err), .busy(busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Monitor: every pulse must match the oldest expected outcome, in kind, data and cycle
   always @(negedge clk) begin
      if (!rst && (rx_valid || frame_err)) begin
         exp_t e;
         check("pulse_exclusive", {30'd0, rx_valid, frame_err} == 32'd3, 32'd0);
         if (exp_q.size() == 0) begin
            check("unexpected_pulse", {30'd0, rx_valid, frame_err}, 32'd0);
         end else begin
            e = exp_q.pop_front();
            check("pulse_kind_err", {31'd0, frame_err}, {31'd0, e.is_err});
            check("pulse_kind_valid", {31'd0, rx_valid}, {31'd0, !e.is_err});
            check("rx_data", {16'd0, rx_data}, {16'd0, e.data});
            check("pulse_latency", cyc, e.due);
         end
      end
   end

   // One frame from a mode-0 master; rst_at >= 0 pulses reset before that bit with cs held low
   task automatic send_frame(input logic [31:0] word, input int nbits, input int half,
                             input logic [W-1:0] txw, input logic [W-1:0] mid_tx,
                             input int rst_at, input int gap);
      bit           live = 1'b1;
      logic [W-1:0] capt = 16'h0000;
      logic         exp_bit;
      exp_t         e;
      tx_data = txw;
      cs = 1'b0;
      for (int i = 0; i < nbits; i++) begin
         if (i == rst_at) begin
            rst = 1'b1;
            repeat (2) @(negedge clk);
            rst = 1'b0;
            live = 1'b0;
            last_good = 16'h0000;
            @(negedge clk);
            check("busy_after_rst", {31'd0, busy}, 32'd0);
            check("rx_data_after_rst", {16'd0, rx_data}, 32'd0);
         end
         mosi = word[nbits-1-i];
         repeat (half) @(negedge clk);
         exp_bit = (live && i < W) ? txw[W-1-i] : 1'b0;
         check($sformatf("miso_bit%0d", i), {31'd0, miso}, {31'd0, exp_bit});
         if (i < W) capt[W-1-i] = miso;
         if (i == 0) check("busy_in_frame", {31'd0, busy}, {31'd0, live});
         sclk = 1'b1;
         repeat (half) @(negedge clk);
         sclk = 1'b0;
         if (i == 0) tx_data = mid_tx;
      end
      if (live && nbits == W) check("miso_word", {16'd0, capt}, {16'd0, txw});
      repeat (half) @(negedge clk);
      cs = 1'b1;
      if (live) begin
         e.is_err = (nbits != W);
         if (nbits == W) last_good = word[W-1:0];
         e.data = last_good;
         e.due  = cyc + 1 + SYNC;
         exp_q.push_back(e);
      end
      for (int g = 1; g <= gap; g++) begin
         @(negedge clk);
         if (g == SYNC + 1) begin
            check("busy_between", {31'd0, busy}, 32'd0);
            check("miso_idle", {31'd0, miso}, 32'd0);
         end
      end
      for (int t = 0; t < 20 && exp_q.size() != 0; t++) begin
         @(negedge clk);
         #1;
      end
      if (exp_q.size() != 0) begin
         check("pulse_timeout", exp_q.size(), 32'd0);
         exp_q.delete();
      end
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check("rst_miso", {31'd0, miso}, 32'd0);
      check("rst_rx_data", {16'd0, rx_data}, 32'd0);
      check("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
      check("rst_frame_err", {31'd0, frame_err}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      rst = 1'b0;
      repeat (6) @(negedge clk);

      send_frame(32'h0000A5C3, 16, 50, 16'h3C5A, 16'h3C5A, -1, 10);
      send_frame(32'h00001111, 16, 6, 16'h8001, 16'hFFFF, -1, 8);
      send_frame(32'h00001234, 15, 5, 16'h0F0F, 16'h0F0F, -1, 8);
      send_frame(32'h0001ABCD, 17, 5, 16'h7777, 16'h7777, -1, 8);
      send_frame(32'h00001234, 16, 5, 16'h4321, 16'h4321, 8, 8);
      send_frame(32'h00001234, 16, 5, 16'h1357, 16'h1357, -1, 8);
      send_frame(32'h0000FFFF, 16, 4, 16'hAAAA, 16'hAAAA, -1, 4);
      send_frame(32'h00000000, 16, 4, 16'h5555, 16'h5555, -1, 4);
      send_frame(32'h00005AA5, 16, 3, 16'hC0DE, 16'h0000, -1, 6);

      for (int r = 0; r < 20; r++) begin
         int n;
         n = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 18) : W;
         send_frame($urandom, n, $urandom_range(3, 12), 16'($urandom), 16'($urandom),
                    -1, $urandom_range(4, 9));
      end

      repeat (10) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
